// File: rtl/mem_bus_pkg.sv
// Shared memory-bus command encoding and arbiter state type.
// Used by the arbiter and by the CPU controller.
package mem_bus_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b11;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signals between the CPU controller, the DMA/loader, the RAM and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_bus_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    // Handshake: dma_req is a level held until the DMA is done. dma_gnt is
    // registered and means the DMA owns the bus in this cycle. cpu_wait=1
    // means the CPU command is not serviced and the CPU must hold
    // cmd/addr/state until cpu_wait=0.
    logic [1:0]    cpu_mem_cmd;
    logic [AW-1:0] cpu_mem_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_wait;
    logic          dma_req;
    logic [1:0]    dma_cmd;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic [DW-1:0] dma_rdata;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_mem_cmd, cpu_mem_addr, cpu_wdata, dma_req, dma_cmd,
               dma_addr, dma_wdata, mem_rdata,
        output cpu_rdata, cpu_wait, dma_gnt, dma_rdata, mem_cmd, mem_addr,
               mem_wdata
    );

    modport master (
        output cpu_mem_cmd, cpu_mem_addr, cpu_wdata, dma_req, dma_cmd,
               dma_addr, dma_wdata, mem_rdata,
        input  cpu_rdata, cpu_wait, dma_gnt, dma_rdata, mem_cmd, mem_addr,
               mem_wdata
    );

endinterface

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for the DMA starvation count and the DMA burst beat count.
module arb_sat_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == W'(MAX));
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single RAM port: CPU by default, DMA on CPU idle
// or after a starvation limit, for at most MAX_BURST counted beats per grant.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
    parameter int SW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_arbiter_if.slave    bus,
    output arb_state_t          state_o,
    output logic [BW-1:0]       beat_cnt_o,
    output logic [SW-1:0]       starve_cnt_o
);

    arb_state_t state_q, state_d;
    logic       just_left_q, just_left_d;
    logic       in_dma, dma_beat, entering_dma;
    logic       starve_at_max, beat_at_max;

    assign in_dma   = (state_q == S_DMA);
    assign dma_beat = in_dma && (bus.dma_cmd != MNONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CPU: begin
                // just_left_q guarantees the CPU one serviced cycle between bursts
                if (bus.dma_req && !just_left_q &&
                    ((bus.cpu_mem_cmd == MNONE) || starve_at_max)) begin
                    state_d = S_DMA;
                end
            end
            S_DMA: begin
                if (!bus.dma_req || (dma_beat && beat_at_max)) begin
                    state_d = S_CPU;
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    assign entering_dma = !in_dma && (state_d == S_DMA);
    assign just_left_d  = in_dma && (state_d == S_CPU);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_CPU;
            just_left_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            just_left_q <= just_left_d;
        end
    end

    arb_sat_counter #(.MAX(STARVE_LIMIT), .W(SW)) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (!in_dma && bus.dma_req),
        .clr    (entering_dma || !bus.dma_req),
        .cnt    (starve_cnt_o),
        .at_max (starve_at_max)
    );

    // at_max marks the last allowed beat of a burst
    arb_sat_counter #(.MAX(MAX_BURST - 1), .W(BW)) u_beat_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (dma_beat),
        .clr    (entering_dma),
        .cnt    (beat_cnt_o),
        .at_max (beat_at_max)
    );

    assign bus.mem_cmd   = !reset ? MNONE : (in_dma ? bus.dma_cmd : bus.cpu_mem_cmd);
    assign bus.mem_addr  = in_dma ? bus.dma_addr  : bus.cpu_mem_addr;
    assign bus.mem_wdata = in_dma ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.cpu_wait  = reset && in_dma;
    assign bus.dma_gnt   = in_dma;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_rdata = bus.mem_rdata;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural RAM on the memory side.
// Walks reset, forced grant, DMA read/drop, full burst, blocked CPU write, mid-burst reset.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    arb_state_t state;
    logic [2:0] beat_cnt;
    logic [2:0] starve_cnt;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(9), .DW(16)) bus ();

    mem_bus_arbiter #(.MAX_BURST(8), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .state_o      (state),
        .beat_cnt_o   (beat_cnt),
        .starve_cnt_o (starve_cnt)
    );

    logic [15:0] ram [0:511];
    int          wr_020;
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_cmd == MWRITE) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_addr == 9'h020) wr_020 <= wr_020 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b0;
        bus.cpu_mem_cmd  = MREAD;
        bus.cpu_mem_addr = 9'h005;
        bus.cpu_wdata    = 16'h0000;
        bus.dma_req      = 1'b1;
        bus.dma_cmd      = MNONE;
        bus.dma_addr     = 9'h000;
        bus.dma_wdata    = 16'h0000;
        wr_020           = 0;
        for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
        for (int i = 0; i < 3; i++) ram[9'h030 + i] = 16'(16'hC000 + i);

        // reset held with CPU busy and DMA requesting
        repeat (2) begin
            step();
            check("rst_mem_cmd", bus.mem_cmd, MNONE);
            check("rst_gnt", bus.dma_gnt, 1'b0);
            check("rst_wait", bus.cpu_wait, 1'b0);
        end
        check("rst_state", state, S_CPU);
        check("rst_starve", starve_cnt, 0);
        reset = 1'b1;
        #1;
        check("rel_mem_cmd", bus.mem_cmd, MREAD);
        check("rel_mem_addr", bus.mem_addr, 9'h005);

        // CPU keeps reading: starvation counter climbs, grant forced on 5th edge
        for (int i = 1; i <= 4; i++) begin
            step();
            #1;
            check("starve_cnt", starve_cnt, i);
            check("starve_gnt", bus.dma_gnt, 1'b0);
            check("starve_wait", bus.cpu_wait, 1'b0);
        end
        step();
        #1;
        check("forced_gnt", bus.dma_gnt, 1'b1);
        check("forced_wait", bus.cpu_wait, 1'b1);
        check("forced_starve_clr", starve_cnt, 0);
        check("forced_beat_clr", beat_cnt, 0);

        // three DMA reads, then drop the request
        bus.dma_cmd = MREAD;
        for (int i = 0; i < 3; i++) begin
            bus.dma_addr = 9'(9'h030 + i);
            #1;
            check("rd_mem_cmd", bus.mem_cmd, MREAD);
            check("rd_mem_addr", bus.mem_addr, 9'h030 + i);
            check("rd_dma_rdata", bus.dma_rdata, 16'hC000 + i);
            check("rd_wait", bus.cpu_wait, 1'b1);
            check("rd_beat", beat_cnt, i);
            step();
        end
        bus.dma_req = 1'b0;
        bus.dma_cmd = MNONE;
        #1;
        check("drop_gnt_hold", bus.dma_gnt, 1'b1);
        check("drop_wait_hold", bus.cpu_wait, 1'b1);
        step();
        #1;
        check("drop_gnt", bus.dma_gnt, 1'b0);
        check("drop_wait", bus.cpu_wait, 1'b0);
        check("drop_mem_cmd", bus.mem_cmd, MREAD);
        step();

        // CPU idle: grant at next edge, 8-beat write burst to 0x010..0x017
        bus.cpu_mem_cmd = MNONE;
        bus.dma_req     = 1'b1;
        bus.dma_cmd     = MWRITE;
        bus.dma_addr    = 9'h010;
        bus.dma_wdata   = 16'hA000;
        #1;
        check("idle_pre_gnt", bus.dma_gnt, 1'b0);
        step();
        #1;
        check("idle_gnt", bus.dma_gnt, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bus.dma_addr  = 9'(9'h010 + i);
            bus.dma_wdata = 16'(16'hA000 + i);
            exp_q.push_back(16'(16'hA000 + i));
            #1;
            check("burst_mem_cmd", bus.mem_cmd, MWRITE);
            check("burst_mem_addr", bus.mem_addr, 9'h010 + i);
            check("burst_beat", beat_cnt, i);
            step();
        end
        bus.dma_cmd = MNONE;
        #1;
        check("burst_end_gnt", bus.dma_gnt, 1'b0);
        check("burst_end_state", state, S_CPU);
        step();
        #1;
        check("fair_block_gnt", bus.dma_gnt, 1'b0);
        step();
        #1;
        check("regrant_gnt", bus.dma_gnt, 1'b1);
        for (int i = 0; i < 8; i++) check("burst_ram", ram[9'h010 + i], exp_q.pop_front());
        check("burst_ram_past_end", ram[9'h018], 16'h0000);

        // CPU write while DMA owns the bus must wait
        bus.cpu_mem_cmd  = MWRITE;
        bus.cpu_mem_addr = 9'h020;
        bus.cpu_wdata    = 16'hBEEF;
        bus.dma_cmd      = MREAD;
        bus.dma_addr     = 9'h030;
        #1;
        check("blk_mem_cmd", bus.mem_cmd, MREAD);
        check("blk_wait", bus.cpu_wait, 1'b1);
        step();
        #1;
        check("blk_ram", ram[9'h020], 16'h0000);
        check("blk_wr_cnt", wr_020, 0);
        bus.dma_req = 1'b0;
        step();
        #1;
        check("blk_release_wait", bus.cpu_wait, 1'b0);
        check("blk_release_cmd", bus.mem_cmd, MWRITE);
        check("blk_release_addr", bus.mem_addr, 9'h020);
        check("blk_ram_pre", ram[9'h020], 16'h0000);
        step();
        bus.cpu_mem_cmd = MNONE;
        #1;
        check("blk_ram_post", ram[9'h020], 16'hBEEF);
        check("blk_wr_once", wr_020, 1);
        step();
        #1;
        check("blk_wr_once_later", wr_020, 1);

        // reset during the 4th beat of a burst
        bus.dma_req   = 1'b1;
        bus.dma_cmd   = MWRITE;
        bus.dma_addr  = 9'h040;
        bus.dma_wdata = 16'hD000;
        step();
        #1;
        check("rb_gnt", bus.dma_gnt, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.dma_addr  = 9'(9'h040 + i);
            bus.dma_wdata = 16'(16'hD000 + i);
            #1;
            check("rb_beat", beat_cnt, i);
            step();
        end
        bus.dma_addr  = 9'h043;
        bus.dma_wdata = 16'hD003;
        #1;
        check("rb_beat4", beat_cnt, 3);
        reset = 1'b0;
        #1;
        check("rb_mem_cmd", bus.mem_cmd, MNONE);
        check("rb_wait", bus.cpu_wait, 1'b0);
        step();
        #1;
        check("rb_state", state, S_CPU);
        check("rb_gnt_drop", bus.dma_gnt, 1'b0);
        check("rb_beat_clr", beat_cnt, 0);
        check("rb_ram_beat3", ram[9'h042], 16'hD002);
        check("rb_ram_beat4", ram[9'h043], 16'h0000);
        reset = 1'b1;
        step();
        #1;
        check("rb_regrant", bus.dma_gnt, 1'b1);
        check("rb_regrant_beat", beat_cnt, 0);
        bus.dma_req = 1'b0;
        bus.dma_cmd = MNONE;
        step();
        #1;
        check("rb_final_gnt", bus.dma_gnt, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
